// File: rtl/ams_pwm_dac.sv
// Dithered single-channel PWM modulator: 8-bit duty plus 16-sub-period dither mask.
// Define AMS_PWM_DITHER_EN to apply the mask; otherwise only the base duty is used.
module ams_pwm_dac #(
    parameter int CCW    = 24,
    parameter int PERIOD = 256
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic [CCW-1:0] cfg_i,
    input  logic           cfg_we_i,
    output logic           pending_o,
    output logic           frame_o,
    output logic           pwm_o
);

    localparam int CW = CCW - 16;
    localparam logic [CW-1:0] CNT_MAX = CW'(PERIOD - 1);

    logic [CW-1:0]  cnt;
    logic [3:0]     sub;
    logic [CCW-1:0] shadow;
    logic [CCW-1:0] active;
    logic [CW-1:0]  duty;
    logic [15:0]    mask;
    logic [CW:0]    thr;
    logic           boundary;

    assign duty     = active[CCW-1:16];
    assign mask     = active[15:0];
    assign boundary = (cnt == CNT_MAX) && (sub == 4'hF);

`ifdef AMS_PWM_DITHER_EN
    // One extra clock of high time in sub-periods whose mask bit is set.
    assign thr = {1'b0, duty} + {{CW{1'b0}}, mask[sub]};
`else
    logic unused_mask;
    assign unused_mask = ^mask;
    assign thr = {1'b0, duty};
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt       <= '0;
            sub       <= '0;
            shadow    <= '0;
            active    <= '0;
            pending_o <= 1'b0;
            frame_o   <= 1'b0;
            pwm_o     <= 1'b0;
        end else begin
            cnt     <= cnt + CW'(1);
            frame_o <= boundary;
            pwm_o   <= ({1'b0, cnt} < thr);
            if (cnt == CNT_MAX)
                sub <= sub + 4'd1;
            if (cfg_we_i)
                shadow <= cfg_i;
            // A write landing on the boundary bypasses the shadow.
            if (boundary) begin
                active    <= cfg_we_i ? cfg_i : shadow;
                pending_o <= 1'b0;
            end else if (cfg_we_i) begin
                pending_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ams_pwm_dac.sv
// Directed bench for ams_pwm_dac: per-sub-period high-time table plus corner sequences.
`timescale 1ns/1ps
module tb_ams_pwm_dac;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] cfg = '0;
    logic        we  = 1'b0;
    logic        pending;
    logic        frame;
    logic        pwm;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [23:0] cfg;
        int          hi_even;
        int          hi_odd;
        string       name;
    } vec_t;

    vec_t vecs[6];

    ams_pwm_dac dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .cfg_i    (cfg),
        .cfg_we_i (we),
        .pending_o(pending),
        .frame_o  (frame),
        .pwm_o    (pwm)
    );

    always #4 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic write_cfg(input logic [23:0] v);
        cfg = v;
        we  = 1'b1;
        @(negedge clk);
        we  = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n;
        n = 0;
        while (frame !== 1'b1 && n < 8300) begin
            @(negedge clk);
            n++;
        end
        if (frame !== 1'b1)
            check({name, "_frame_timeout"}, 0, 1);
    endtask

    // Call at the negedge where frame_o is high; ends at the next one.
    task automatic measure(input int he, input int ho, input string name);
        int total;
        int hi;
        int bad;
        int exp;
        total = 0;
        for (int s = 0; s < 16; s++) begin
            exp = (s % 2 == 0) ? he : ho;
            hi  = 0;
            bad = 0;
            for (int k = 0; k < 256; k++) begin
                @(negedge clk);
                if (pwm === 1'b1) hi++;
                if (pwm !== (k < exp)) bad++;
            end
            total += hi;
            check($sformatf("%s_sub%0d_hi", name, s), hi, exp);
            check($sformatf("%s_sub%0d_shape", name, s), bad, 0);
        end
        check({name, "_frame_total"}, total, 8 * (he + ho));
        check({name, "_next_frame"}, int'(frame), 1);
    endtask

    initial begin
        int n;
        int bad;

        vecs[0] = '{24'h80_0000, 128, 128, "base"};
`ifdef AMS_PWM_DITHER_EN
        vecs[1] = '{24'h40_5555, 65, 64, "dither"};
        vecs[2] = '{24'hFF_FFFF, 256, 256, "full"};
        vecs[3] = '{24'h00_FFFF, 1, 1, "mask_only"};
`else
        vecs[1] = '{24'h40_5555, 64, 64, "dither"};
        vecs[2] = '{24'hFF_FFFF, 255, 255, "full"};
        vecs[3] = '{24'h00_FFFF, 0, 0, "mask_only"};
`endif
        vecs[4] = '{24'h00_0000, 0, 0, "zero"};
        vecs[5] = '{24'hFF_0000, 255, 255, "ff_duty"};

        // Reset hold
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pwm !== 1'b0 || frame !== 1'b0 || pending !== 1'b0) bad++;
        end
        check("reset_hold", bad, 0);
        rst = 1'b0;
        n = 0;
        while (n < 5000) begin
            @(negedge clk);
            n++;
            if (frame === 1'b1) break;
        end
        check("first_frame_delay", n, 4096);

        // Table of steady-state patterns
        for (int v = 0; v < 6; v++) begin
            @(negedge clk);
            write_cfg(vecs[v].cfg);
            check({vecs[v].name, "_pending"}, int'(pending), 1);
            wait_frame(vecs[v].name);
            check({vecs[v].name, "_applied"}, int'(pending), 0);
            measure(vecs[v].hi_even, vecs[v].hi_odd, vecs[v].name);
        end

        // Boundary collision: write lands on cnt=255, sub=15
        for (int i = 0; i < 4095; i++) @(negedge clk);
        write_cfg(24'h10_0000);
        check("collide_pending", int'(pending), 0);
        check("collide_frame", int'(frame), 1);
        measure(16, 16, "collide");

        // Overwrite within one frame
        @(negedge clk);
        write_cfg(24'h20_0000);
        check("ovw_pending1", int'(pending), 1);
        for (int i = 0; i < 100; i++) @(negedge clk);
        write_cfg(24'h30_0000);
        check("ovw_pending2", int'(pending), 1);
        wait_frame("ovw");
        check("ovw_cleared", int'(pending), 0);
        measure(48, 48, "ovw");

        // Mid-frame asynchronous reset
        for (int i = 0; i < 10; i++) @(negedge clk);
        check("pre_rst_pwm", int'(pwm), 1);
        write_cfg(24'h50_0000);
        check("pre_rst_pending", int'(pending), 1);
        #1 rst = 1'b1;
        #1;
        check("async_rst_pwm", int'(pwm), 0);
        check("async_rst_pending", int'(pending), 0);
        check("async_rst_frame", int'(frame), 0);
        @(negedge clk);
        rst = 1'b0;
        wait_frame("post_rst");
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (pwm !== 1'b0) bad++;
        end
        check("post_rst_cleared", bad, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
